// File: rtl/pe_grid_scheduler_if.sv
// pe_grid_scheduler_if
// Bundles the scheduler's data-path buses:
//   - weight buffer read port  : w_rd_en, w_rd_addr -> w_rd_data (data one cycle after strobe)
//   - image buffer read port   : i_rd_en, i_rd_addr -> i_rd_data (data one cycle after strobe)
//   - grid weight multicast    : weight_val_in, tag_row, valid_y
//   - grid image multicast     : image_val_in, tag_col, valid_x
//   - grid psum outputs        : grid_psum (column c at bits [32c+31:32c], 14 columns)
//   - output buffer write port : ofm_wr_en, ofm_wr_addr, ofm_wr_data
// Modport master is the scheduler side, slave is the buffers/grid side.
interface pe_grid_scheduler_if #(
  parameter int ADDR_W = 8
);
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [15:0]       w_rd_data;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [15:0]       i_rd_data;
  logic [15:0]       weight_val_in;
  logic [3:0]        tag_row;
  logic              valid_y;
  logic [15:0]       image_val_in;
  logic [3:0]        tag_col;
  logic              valid_x;
  logic [447:0]      grid_psum;
  logic              ofm_wr_en;
  logic [3:0]        ofm_wr_addr;
  logic [31:0]       ofm_wr_data;

  modport master (
    output w_rd_en, w_rd_addr, input w_rd_data,
    output i_rd_en, i_rd_addr, input i_rd_data,
    output weight_val_in, tag_row, valid_y,
    output image_val_in, tag_col, valid_x,
    input  grid_psum,
    output ofm_wr_en, ofm_wr_addr, ofm_wr_data
  );

  modport slave (
    input  w_rd_en, w_rd_addr, output w_rd_data,
    input  i_rd_en, i_rd_addr, output i_rd_data,
    input  weight_val_in, tag_row, valid_y,
    input  image_val_in, tag_col, valid_x,
    output grid_psum,
    input  ofm_wr_en, ofm_wr_addr, ofm_wr_data
  );
endinterface

// File: rtl/pe_grid_scheduler.sv
// pe_grid_scheduler
// Sequences one pass of a 12x14 PE grid: reads R weights and C image values
// from the input buffers, multicasts them on the tagged grid buses, waits
// DRAIN_CYCLES for the array to settle, then writes the C column psums to the
// output buffer and pulses done.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pass request, honoured only in IDLE
//   cfg_rows/cols   active rows/cols (clamped to 12/14), latched at start
//   bus             buffer read ports, grid buses, psum input, ofm write port
//   busy, done      pass in progress / one-cycle completion pulse
//   perf_cycles     busy-cycle counter
// Optional feature macro: SCHED_PERF_CNT_EN enables perf_cycles counting;
// without it perf_cycles is tied to 0.
module pe_grid_scheduler #(
  parameter int DRAIN_CYCLES = 16,
  parameter int ADDR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cfg_rows,
  input  logic [3:0]           cfg_cols,
  pe_grid_scheduler_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state, w_state_next;
  logic [7:0]        r_cnt, w_cnt_next;
  logic [3:0]        r_rows, w_rows_next;
  logic [3:0]        r_cols, w_cols_next;
  logic [3:0]        r_n, w_n_next;

  logic              r_w_rd_en, w_w_rd_en_next;
  logic [ADDR_W-1:0] r_w_rd_addr, w_w_rd_addr_next;
  logic              r_i_rd_en, w_i_rd_en_next;
  logic [ADDR_W-1:0] r_i_rd_addr, w_i_rd_addr_next;
  logic              r_valid_y, w_valid_y_next;
  logic [3:0]        r_tag_row, w_tag_row_next;
  logic              r_valid_x, w_valid_x_next;
  logic [3:0]        r_tag_col, w_tag_col_next;
  logic              r_ofm_wr_en, w_ofm_wr_en_next;
  logic [3:0]        r_ofm_wr_addr, w_ofm_wr_addr_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;

  // Psum columns as an array; the two spare slots keep any 4-bit index in range.
  logic [31:0]       w_psum_col [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_psum_col
      if (gi < 14) begin : g_real
        assign w_psum_col[gi] = bus.grid_psum[32*gi +: 32];
      end else begin : g_pad
        assign w_psum_col[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rows        <= '0;
      r_cols        <= '0;
      r_n           <= '0;
      r_w_rd_en     <= 1'b0;
      r_w_rd_addr   <= '0;
      r_i_rd_en     <= 1'b0;
      r_i_rd_addr   <= '0;
      r_valid_y     <= 1'b0;
      r_tag_row     <= '0;
      r_valid_x     <= 1'b0;
      r_tag_col     <= '0;
      r_ofm_wr_en   <= 1'b0;
      r_ofm_wr_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_rows        <= w_rows_next;
      r_cols        <= w_cols_next;
      r_n           <= w_n_next;
      r_w_rd_en     <= w_w_rd_en_next;
      r_w_rd_addr   <= w_w_rd_addr_next;
      r_i_rd_en     <= w_i_rd_en_next;
      r_i_rd_addr   <= w_i_rd_addr_next;
      r_valid_y     <= w_valid_y_next;
      r_tag_row     <= w_tag_row_next;
      r_valid_x     <= w_valid_x_next;
      r_tag_col     <= w_tag_col_next;
      r_ofm_wr_en   <= w_ofm_wr_en_next;
      r_ofm_wr_addr <= w_ofm_wr_addr_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rows_next  = r_rows;
    w_cols_next  = r_cols;
    w_n_next     = r_n;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rows_next  = (cfg_rows > 4'd12) ? 4'd12 : cfg_rows;
          w_cols_next  = (cfg_cols > 4'd14) ? 4'd14 : cfg_cols;
          w_n_next     = (w_rows_next > w_cols_next) ? w_rows_next : w_cols_next;
          w_cnt_next   = '0;
          w_state_next = (w_rows_next == 4'd0 || w_cols_next == 4'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_cnt == {4'd0, r_n - 4'd1}) begin
          w_state_next = S_FLUSH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_FLUSH: begin
        w_state_next = S_DRAIN;
        w_cnt_next   = '0;
      end
      S_DRAIN: begin
        if (r_cnt == 8'(DRAIN_CYCLES - 1)) begin
          w_state_next = S_WB;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_WB: begin
        if (r_cnt == {4'd0, r_cols - 4'd1}) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so that they line up with
    // that state once registered.
    w_busy_next        = (w_state_next != S_IDLE);
    w_done_next        = (w_state_next == S_DONE);
    w_w_rd_en_next     = (w_state_next == S_LOAD) && ({4'd0, w_rows_next} > w_cnt_next);
    w_w_rd_addr_next   = w_w_rd_en_next ? ADDR_W'(w_cnt_next) : '0;
    w_i_rd_en_next     = (w_state_next == S_LOAD) && ({4'd0, w_cols_next} > w_cnt_next);
    w_i_rd_addr_next   = w_i_rd_en_next ? ADDR_W'(w_cnt_next) : '0;
    // A read strobe is only ever high in LOAD, where r_cnt is its index, so the
    // bus tag for next cycle is simply the current index.
    w_valid_y_next     = r_w_rd_en;
    w_tag_row_next     = r_w_rd_en ? r_cnt[3:0] : '0;
    w_valid_x_next     = r_i_rd_en;
    w_tag_col_next     = r_i_rd_en ? r_cnt[3:0] : '0;
    w_ofm_wr_en_next   = (w_state_next == S_WB);
    w_ofm_wr_addr_next = w_ofm_wr_en_next ? w_cnt_next[3:0] : '0;
  end

  // Buffer data arrives the cycle after the strobe, in the same cycle the
  // registered valid is high, so the data lanes are the live read data gated
  // by the registered valid. Psums are likewise taken in the WB cycle itself.
  assign bus.w_rd_en       = r_w_rd_en;
  assign bus.w_rd_addr     = r_w_rd_addr;
  assign bus.i_rd_en       = r_i_rd_en;
  assign bus.i_rd_addr     = r_i_rd_addr;
  assign bus.valid_y       = r_valid_y;
  assign bus.tag_row       = r_tag_row;
  assign bus.weight_val_in = r_valid_y ? bus.w_rd_data : '0;
  assign bus.valid_x       = r_valid_x;
  assign bus.tag_col       = r_tag_col;
  assign bus.image_val_in  = r_valid_x ? bus.i_rd_data : '0;
  assign bus.ofm_wr_en     = r_ofm_wr_en;
  assign bus.ofm_wr_addr   = r_ofm_wr_addr;
  assign bus.ofm_wr_data   = r_ofm_wr_en ? w_psum_col[r_ofm_wr_addr] : '0;
  assign busy              = r_busy;
  assign done              = r_done;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/pe_grid_scheduler.md
PE_GRID_SCHEDULER -- requirements
Module: pe_grid_scheduler

Interface
REQ-001 Parameter DRAIN_CYCLES, default 16, cycles waited after the last bus transfer before psum capture (legal range 1..255).
REQ-002 Parameter ADDR_W, default 8, width of the weight and image buffer read addresses.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to run one pass; sampled only in IDLE.
REQ-006 cfg_rows  input  4  active PE rows, latched at an accepted start.
REQ-007 cfg_cols  input  4  active PE columns, latched at an accepted start.
REQ-008 w_rd_en, w_rd_addr  output  1, ADDR_W  weight buffer read strobe and address.
REQ-009 w_rd_data  input  16  weight data, valid the cycle after w_rd_en.
REQ-010 i_rd_en, i_rd_addr  output  1, ADDR_W  image buffer read strobe and address.
REQ-011 i_rd_data  input  16  image data, valid the cycle after i_rd_en.
REQ-012 weight_val_in, tag_row, valid_y  output  16, 4, 1  grid weight multicast bus.
REQ-013 image_val_in, tag_col, valid_x  output  16, 4, 1  grid image multicast bus.
REQ-014 grid_psum  input  448  grid column psum outputs; column c occupies bits [32c+31:32c].
REQ-015 ofm_wr_en, ofm_wr_addr, ofm_wr_data  output  1, 4, 32  output buffer write port.
REQ-016 busy, done  output  1, 1  pass in progress; one-cycle pass-complete pulse.
REQ-017 perf_cycles  output  32  busy-cycle counter (see Configuration).

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, FLUSH, DRAIN, WB and DONE; all outputs are registered.
REQ-019 In IDLE, start=1 SHALL latch R=min(cfg_rows,12) and C=min(cfg_cols,14), with the accepted start cycle counted as cycle 0.
REQ-020 If R=0 or C=0, the FSM SHALL go to DONE at cycle 1, with no reads, bus valids or writes; otherwise it SHALL enter LOAD at cycle 1.
REQ-021 LOAD SHALL last N=max(R,C) cycles with index k=0..N-1: w_rd_en=1 and w_rd_addr=k when k<R; i_rd_en=1 and i_rd_addr=k when k<C.
REQ-022 For each index k read, the cycle after the read SHALL drive valid_y=1, tag_row=k and weight_val_in=w_rd_data, and likewise valid_x=1, tag_col=k and image_val_in=i_rd_data.
REQ-023 FLUSH SHALL last one cycle, carry the last bus transfer and issue no reads.
REQ-024 DRAIN SHALL last exactly DRAIN_CYCLES cycles with all valids low.
REQ-025 WB SHALL last C cycles: in its cycle j it drives ofm_wr_en=1, ofm_wr_addr=j and ofm_wr_data=grid_psum column j, sampled in that WB cycle.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 in every state except IDLE.
REQ-027 For R=12, C=14 and DRAIN_CYCLES=16, done SHALL assert at cycle N+2+DRAIN_CYCLES+C=46.
REQ-028 start while not in IDLE SHALL be ignored, including in the DONE cycle, and cfg inputs SHALL have no effect mid-pass.
REQ-029 When valid_x or valid_y is low, its data and tag outputs SHALL be 0; unused read addresses SHALL be 0.

Reset
REQ-030 rst=1 SHALL force IDLE and, on the next edge, drive every output to 0 and clear the latched R, C and all counters.
REQ-031 rst asserted mid-pass SHALL abort the pass with no done pulse and no further reads or writes.
REQ-032 rst SHALL take priority over start in the same cycle.

Configuration
REQ-033 With SCHED_PERF_CNT_EN defined, perf_cycles SHALL increment by 1 every cycle busy=1, saturate at 2^32-1, and clear only on rst.
REQ-034 Without SCHED_PERF_CNT_EN, the port SHALL remain present and perf_cycles SHALL be constant 0.

Verification
REQ-035 Full pass: rst, then start with cfg 12/14, w_rd_data=addr+1, i_rd_data=10*(addr+1) -> tag_row 0..11 with weights 1..12 at cycles 2..13, tag_col 0..13 with images 10..140 at cycles 2..15, done at cycle 46.
REQ-036 Writeback: cfg 3/3 with grid_psum column 2=90 and other columns 0 -> writes addr 0,1,2 with data 0,0,90, and done one cycle after the last write.
REQ-037 Boundaries: cfg_rows=0 -> done at cycle 1 with no valids; cfg 15/15 -> behaves as 12/14; start during DRAIN -> ignored, one done only.
REQ-038 Reset mid-LOAD: rst at cycle 5 of a 12/14 pass -> next cycle all outputs 0, no done; a new start then runs a full pass.
REQ-039 Perf counter: 12/14 pass with SCHED_PERF_CNT_EN -> perf_cycles=46; same pass without the macro -> perf_cycles=0.
